// File: rtl/cache_tag_pkg.sv
// Shared widths, tag-word bit positions, FSM states and the tag-word builder
// for the 4-way tag lookup controller.
package cache_tag_pkg;

  localparam int TAG_W    = 11;
  localparam int LINE_W   = 10;
  localparam int OFFSET_W = 4;
  localparam int ADDR_W   = TAG_W + LINE_W + OFFSET_W;
  localparam int WORD_W   = TAG_W + 3;
  localparam int LINES    = 1 << LINE_W;

  localparam int TAG_VALID = 13;
  localparam int TAG_DIRTY = 12;
  localparam int TAG_RSVD  = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_COMPARE   = 3'd2,
    ST_TAG_WR    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_REFILL    = 3'd5,
    ST_RESP      = 3'd6
  } state_e;

  // Reserved bit is always written as zero.
  function automatic logic [WORD_W-1:0] build_tag_word(input logic valid,
                                                       input logic dirty,
                                                       input logic [TAG_W-1:0] tag);
    return {valid, dirty, 1'b0, tag};
  endfunction

endpackage

// File: rtl/tag_lookup_ctrl_if.sv
// Bundle of request/response, tag-bank and next-level memory signals around
// the tag lookup controller; slave = controller view, master = environment view.
interface tag_lookup_ctrl_if;
  import cache_tag_pkg::*;

  // Handshakes: a request transfers on a rising edge where Req_Valid and
  // Req_Ready are both 1; the requester holds Req_Valid/Req_Write/Req_Addr
  // stable until then. Mem_Req/Mem_Wr/Mem_Addr stay stable until a one-cycle
  // Mem_Ack pulse; Resp_Valid is a one-cycle pulse with no back-pressure.
  logic              Req_Valid;
  logic              Req_Ready;
  logic              Req_Write;
  logic [ADDR_W-1:0] Req_Addr;
  logic              Resp_Valid;
  logic              Resp_Hit;
  logic [1:0]        Resp_Way;
  logic [WORD_W-1:0] Tag1;
  logic [WORD_W-1:0] Tag2;
  logic [WORD_W-1:0] Tag3;
  logic [WORD_W-1:0] Tag4;
  logic [LINE_W-1:0] Tag_LineNumber;
  logic              Tag_CEn;
  logic              Tag_WEn;
  logic [1:0]        Tag_Way_Sel;
  logic [WORD_W-1:0] Tag_Write_Data;
  logic              Mem_Req;
  logic              Mem_Wr;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Ack;
  logic              Err_MultiHit;

  modport slave (
    input  Req_Valid, Req_Write, Req_Addr, Tag1, Tag2, Tag3, Tag4, Mem_Ack,
    output Req_Ready, Resp_Valid, Resp_Hit, Resp_Way, Tag_LineNumber, Tag_CEn,
           Tag_WEn, Tag_Way_Sel, Tag_Write_Data, Mem_Req, Mem_Wr, Mem_Addr,
           Err_MultiHit
  );

  modport master (
    output Req_Valid, Req_Write, Req_Addr, Tag1, Tag2, Tag3, Tag4, Mem_Ack,
    input  Req_Ready, Resp_Valid, Resp_Hit, Resp_Way, Tag_LineNumber, Tag_CEn,
           Tag_WEn, Tag_Way_Sel, Tag_Write_Data, Mem_Req, Mem_Wr, Mem_Addr,
           Err_MultiHit
  );

endinterface

// File: rtl/plru_tree_4way.sv
// Combinational 4-way tree-PLRU: victim pick from {b2,b1,b0} and the
// updated bits after an access to a given way.
module plru_tree_4way (
  input  logic [2:0] plru_bits,
  input  logic [1:0] access_way,
  output logic [1:0] victim,
  output logic [2:0] next_bits
);

  always_comb begin
    victim    = plru_bits[0] ? (plru_bits[2] ? 2'd3 : 2'd2)
                             : (plru_bits[1] ? 2'd1 : 2'd0);
    next_bits = plru_bits;
    // Point the root away from the accessed half, the leaf away from the way.
    if (!access_way[1]) begin
      next_bits[0] = 1'b1;
      next_bits[1] = ~access_way[0];
    end else begin
      next_bits[0] = 1'b0;
      next_bits[2] = ~access_way[0];
    end
  end

endmodule

// File: rtl/tag_lookup_ctrl.sv
// Cache tag controller: hit detection against the 4-way tag bank, PLRU victim
// choice, dirty writeback and refill sequencing, one request in flight.
module tag_lookup_ctrl
  import cache_tag_pkg::*;
(
  input  logic              CLK,
  input  logic              Reset,
  tag_lookup_ctrl_if.slave  bus,
  output logic [2:0]        dbg_state
);

  state_e             state_q;
  logic               write_q;
  logic [TAG_W-1:0]   tag_q;
  logic [LINE_W-1:0]  line_q;
  logic [1:0]         way_q;
  logic               hit_q;
  logic [TAG_W-1:0]   victim_tag_q;
  logic [WORD_W-1:0]  wr_word_q;
  logic               err_q;
  logic [3*LINES-1:0] plru_flat;

  logic [WORD_W-1:0]  tags [4];
  logic [3:0]         hit;
  logic [3:0]         invalid;
  logic               any_hit;
  logic               multi_hit;
  logic               has_invalid;
  logic [1:0]         hit_way;
  logic [1:0]         inv_way;
  logic [1:0]         victim_way;
  logic [1:0]         plru_victim;
  logic [1:0]         access_way;
  logic [2:0]         plru_cur;
  logic [2:0]         plru_next;
  logic [11:0]        plru_base;
  logic               plru_upd;
  logic               unused_bits;

  assign tags[0] = bus.Tag1;
  assign tags[1] = bus.Tag2;
  assign tags[2] = bus.Tag3;
  assign tags[3] = bus.Tag4;

  always_comb begin
    hit     = '0;
    invalid = '0;
    for (int w = 0; w < 4; w++) begin
      hit[w]     = tags[w][TAG_VALID] && (tags[w][TAG_W-1:0] == tag_q);
      invalid[w] = ~tags[w][TAG_VALID];
    end
    hit_way = '0;
    inv_way = '0;
    for (int w = 3; w >= 0; w--) begin
      if (hit[w])     hit_way = 2'(w);
      if (invalid[w]) inv_way = 2'(w);
    end
  end

  assign any_hit     = |hit;
  assign multi_hit   = (hit & (hit - 4'd1)) != 4'd0;
  assign has_invalid = |invalid;
  assign victim_way  = has_invalid ? inv_way : plru_victim;

  assign plru_base  = 12'(line_q) * 12'd3;
  assign plru_cur   = plru_flat[plru_base +: 3];
  assign access_way = (state_q == ST_COMPARE) ? hit_way : way_q;
  // Hits touch the PLRU during compare; fills touch it when the refill completes.
  assign plru_upd   = ((state_q == ST_COMPARE) && any_hit) ||
                      ((state_q == ST_REFILL) && bus.Mem_Ack);

  plru_tree_4way u_plru (
    .plru_bits  (plru_cur),
    .access_way (access_way),
    .victim     (plru_victim),
    .next_bits  (plru_next)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      plru_flat <= '0;
    end else if (plru_upd) begin
      plru_flat[plru_base +: 3] <= plru_next;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      tag_q        <= '0;
      line_q       <= '0;
      way_q        <= '0;
      hit_q        <= 1'b0;
      victim_tag_q <= '0;
      wr_word_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.Req_Valid) begin
            write_q <= bus.Req_Write;
            tag_q   <= bus.Req_Addr[ADDR_W-1 -: TAG_W];
            line_q  <= bus.Req_Addr[OFFSET_W +: LINE_W];
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: state_q <= ST_COMPARE;
        ST_COMPARE: begin
          if (multi_hit) err_q <= 1'b1;
          if (any_hit) begin
            way_q     <= hit_way;
            hit_q     <= 1'b1;
            wr_word_q <= build_tag_word(1'b1, 1'b1, tag_q);
            if (write_q && !tags[hit_way][TAG_DIRTY]) state_q <= ST_TAG_WR;
            else                                      state_q <= ST_RESP;
          end else begin
            way_q        <= victim_way;
            hit_q        <= 1'b0;
            victim_tag_q <= tags[victim_way][TAG_W-1:0];
            wr_word_q    <= build_tag_word(1'b1, write_q, tag_q);
            if (tags[victim_way][TAG_VALID] && tags[victim_way][TAG_DIRTY])
              state_q <= ST_WRITEBACK;
            else
              state_q <= ST_REFILL;
          end
        end
        ST_WRITEBACK: if (bus.Mem_Ack) state_q <= ST_REFILL;
        ST_REFILL:    if (bus.Mem_Ack) state_q <= ST_TAG_WR;
        ST_TAG_WR:    state_q <= ST_RESP;
        ST_RESP:      state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory-side outputs decode straight from state so reset drops Mem_Req at once.
  assign bus.Req_Ready      = (state_q == ST_IDLE);
  assign bus.Resp_Valid     = (state_q == ST_RESP);
  assign bus.Resp_Hit       = hit_q;
  assign bus.Resp_Way       = way_q;
  assign bus.Tag_LineNumber = line_q;
  assign bus.Tag_CEn        = !((state_q == ST_LOOKUP) || (state_q == ST_TAG_WR));
  assign bus.Tag_WEn        = !(state_q == ST_TAG_WR);
  assign bus.Tag_Way_Sel    = way_q;
  assign bus.Tag_Write_Data = wr_word_q;
  assign bus.Mem_Req        = (state_q == ST_WRITEBACK) || (state_q == ST_REFILL);
  assign bus.Mem_Wr         = (state_q == ST_WRITEBACK);
  assign bus.Mem_Addr       = {(state_q == ST_WRITEBACK) ? victim_tag_q : tag_q,
                               line_q, {OFFSET_W{1'b0}}};
  assign bus.Err_MultiHit   = err_q;
  assign dbg_state          = state_q;

  assign unused_bits = ^{bus.Req_Addr[OFFSET_W-1:0], tags[0][TAG_RSVD],
                         tags[1][TAG_RSVD], tags[2][TAG_RSVD], tags[3][TAG_RSVD]};

endmodule
